// File: rtl/whack_datapath.sv
// -----------------------------------------------------------------------------
// whack_datapath
//   Game datapath for a four-mole whack-a-mole. The controller pulses
//   round_start and the block releases a mole once the player's hands are off
//   the keys. The player then has a fixed window to hit the lit mole. Each
//   round ends with a one-cycle round_done/hit report. A hit adds to the
//   saturating score and a miss costs a life. The game parks in OVER until
//   clear is pulsed.
//
// Parameters
//   WINDOW_CYCLES  mole-visible window length in clk cycles (>= 4)
//   LIVES_INIT     lives loaded at reset and on clear (1..3)
//   LFSR_SEED      nonzero reset value of the mole-select LFSR
//
// Ports
//   clk          in   system clock, rising edge
//   Resetn       in   asynchronous active-low reset
//   round_start  in   one-cycle pulse requesting a new round (honoured in IDLE)
//   clear        in   one-cycle pulse restarting the game (honoured in OVER)
//   keys[3:0]    in   synchronised hit buttons, active-high level
//   mole[3:0]    out  one-hot lit mole, 0 when none is shown
//   round_done   out  one-cycle end-of-round pulse
//   hit          out  round result, meaningful only with round_done
//   score[7:0]   out  hits this game, saturating at 255
//   lives[1:0]   out  remaining lives
//   game_over    out  high while in OVER
//
// Build option
//   WHACK_SPEEDUP_EN  when defined, every 8th hit shortens the window by
//                     WINDOW_CYCLES/8, down to a floor of WINDOW_CYCLES/4.
//                     Reset and clear restore the full window.
// -----------------------------------------------------------------------------
module whack_datapath #(
  parameter int         WINDOW_CYCLES = 50_000_000,
  parameter int         LIVES_INIT    = 3,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       Resetn,
  input  logic       round_start,
  input  logic       clear,
  input  logic [3:0] keys,
  output logic [3:0] mole,
  output logic       round_done,
  output logic       hit,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int             TW        = $clog2(WINDOW_CYCLES + 1);
  localparam logic [TW-1:0]  WIN_FULL  = TW'(WINDOW_CYCLES);
  localparam logic [1:0]     LIVES_RST = 2'(LIVES_INIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RELEASE = 3'd1,
    ACTIVE  = 3'd2,
    RESULT  = 3'd3,
    OVER    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      lfsr_q;
  logic [3:0]      mole_d;
  logic            round_done_d, hit_d, game_over_d;
  logic [7:0]      score_d;
  logic [1:0]      lives_d;
  logic            res_valid, res_hit;
  logic [TW-1:0]   win_cur;

`ifdef WHACK_SPEEDUP_EN
  localparam logic [TW-1:0] WIN_STEP = TW'(WINDOW_CYCLES / 8);
  localparam logic [TW-1:0] WIN_MIN  = TW'(WINDOW_CYCLES / 4);

  logic [TW-1:0] win_q, win_d;

  assign win_cur = win_q;

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) win_q <= WIN_FULL;
    else         win_q <= win_d;
  end
`else
  assign win_cur = WIN_FULL;
`endif

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1. It free-runs in every state so the
  // mole choice depends on how long the player waits between rounds.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      mole       <= 4'b0000;
      round_done <= 1'b0;
      hit        <= 1'b0;
      score      <= 8'd0;
      lives      <= LIVES_RST;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      mole       <= mole_d;
      round_done <= round_done_d;
      hit        <= hit_d;
      score      <= score_d;
      lives      <= lives_d;
      game_over  <= game_over_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    mole_d       = mole;
    round_done_d = 1'b0;
    hit_d        = 1'b0;
    score_d      = score;
    lives_d      = lives;
    res_valid    = 1'b0;
    res_hit      = 1'b0;
`ifdef WHACK_SPEEDUP_EN
    win_d        = win_q;
`endif

    case (state_q)
      IDLE: begin
        if (round_start) state_d = RELEASE;
      end

      // Hold the mole back until every key is up, so a held key cannot score.
      RELEASE: begin
        if (keys == 4'b0000) begin
          state_d = ACTIVE;
          mole_d  = 4'b0001 << lfsr_q[1:0];
          timer_d = win_cur - TW'(1);
        end
      end

      // A key press on the last timer cycle is still judged as a press.
      ACTIVE: begin
        if (keys != 4'b0000) begin
          res_valid = 1'b1;
          res_hit   = (keys == mole);
        end else if (timer_q == '0) begin
          res_valid = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      // Score and lives were updated on entry, so lives==0 means the last
      // life was just lost.
      RESULT: begin
        state_d = (lives == 2'd0) ? OVER : IDLE;
      end

      OVER: begin
        if (clear) begin
          state_d = IDLE;
          score_d = 8'd0;
          lives_d = LIVES_RST;
`ifdef WHACK_SPEEDUP_EN
          win_d   = WIN_FULL;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    // Round outcome is registered on entry to RESULT.
    if (res_valid) begin
      state_d      = RESULT;
      mole_d       = 4'b0000;
      round_done_d = 1'b1;
      hit_d        = res_hit;
      if (res_hit) begin
        if (score != 8'hFF) begin
          score_d = score + 8'd1;
`ifdef WHACK_SPEEDUP_EN
          if (score_d[2:0] == 3'd0)
            win_d = (win_q >= WIN_MIN + WIN_STEP) ? win_q - WIN_STEP : WIN_MIN;
`endif
        end
      end else begin
        lives_d = lives - 2'd1;
      end
    end

    game_over_d = (state_d == OVER);
  end

endmodule

// File: tb/tb_whack_datapath.sv
module tb_whack_datapath;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       Resetn = 1'b0;
  logic       round_start = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] keys = 4'b0000;
  logic [3:0] mole;
  logic       round_done;
  logic       hit;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] m_lfsr;
  int         m_score;
  int         m_lives;

  always #5 clk = ~clk;

  whack_datapath #(
    .WINDOW_CYCLES(W),
    .LIVES_INIT   (3),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk        (clk),
    .Resetn     (Resetn),
    .round_start(round_start),
    .clear      (clear),
    .keys       (keys),
    .mole       (mole),
    .round_done (round_done),
    .hit        (hit),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over)
  );

  // x^8+x^6+x^5+x^4+1: the new bit is the XOR of stages 8,6,5,4 and it
  // enters at the low end as the register shifts up.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  always @(posedge clk or negedge Resetn) begin
    if (!Resetn) m_lfsr <= 8'hA5;
    else         m_lfsr <= lfsr_step(m_lfsr);
  end

  // Expected window for the next round, derived from the score alone.
  function automatic int m_window();
    int w;
    w = W;
`ifdef WHACK_SPEEDUP_EN
    w = W - (W / 8) * (m_score / 8);
    if (w < W / 4) w = W / 4;
`endif
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // kind: 0 = correct key, 1 = complement of mole, 2 = random wrong key.
  // press_at: ACTIVE cycle (1-based) on which the key goes down, 0 = never.
  task automatic run_round(input int press_at, input int kind, input bit hold);
    logic [3:0] em;
    logic [3:0] kv;
    int         win;
    bit         exp_hit;

    round_start = 1'b1;
    if (hold) keys = 4'b1000;
    step();
    round_start = 1'b0;
    if (hold) begin
      repeat (3) begin
        chk("mole_while_held", mole, 4'b0000);
        step();
      end
      keys = 4'b0000;
    end
    chk("mole_in_release", mole, 4'b0000);
    em  = 4'b0001 << m_lfsr[1:0];
    win = m_window();
    step();

    for (int k = 1; k <= win; k++) begin
      chk("mole_active", mole, em);
      chk("no_early_done", round_done, 1'b0);
      if (k == press_at) begin
        if (kind == 0) begin
          kv = em;
        end else if (kind == 1) begin
          kv = ~em & 4'hF;
        end else begin
          kv = em ^ 4'($urandom_range(1, 15));
          if (kv == 4'b0000) kv = ~em & 4'hF;
        end
        keys = kv;
      end
      step();
      if (k == press_at) break;
    end

    exp_hit = (press_at >= 1) && (press_at <= win) && (kind == 0);
    if (exp_hit) begin
      if (m_score < 255) m_score++;
    end else begin
      m_lives--;
    end

    chk("round_done", round_done, 1'b1);
    chk("hit", hit, exp_hit);
    chk("mole_in_result", mole, 4'b0000);
    chk("score", score, m_score);
    chk("lives", lives, m_lives);
    keys = 4'b0000;
    step();
    chk("done_one_cycle", round_done, 1'b0);
    chk("game_over", game_over, (m_lives == 0));
  endtask

  task automatic check_over_ignores_start();
    round_start = 1'b1;
    step();
    round_start = 1'b0;
    repeat (3) step();
    chk("over_mole", mole, 4'b0000);
    chk("over_done", round_done, 1'b0);
    chk("over_game_over", game_over, 1'b1);
    chk("over_score_frozen", score, m_score);
    chk("over_lives", lives, 2'd0);
  endtask

  task automatic clear_game();
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_score = 0;
    m_lives = 3;
    chk("clear_game_over", game_over, 1'b0);
    chk("clear_score", score, 8'd0);
    chk("clear_lives", lives, 2'd3);
  endtask

  initial begin
    m_score = 0;
    m_lives = 3;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mole", mole, 4'b0000);
    chk("rst_done", round_done, 1'b0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_score", score, 8'd0);
    chk("rst_lives", lives, 2'd3);
    chk("rst_game_over", game_over, 1'b0);
    Resetn = 1'b1;
    step();

    // Hit on third ACTIVE cycle, then a full timeout
    run_round(3, 0, 0);
    run_round(0, 0, 0);

    // clear outside OVER has no effect
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    chk("clear_ignored_score", score, 8'd1);
    chk("clear_ignored_lives", lives, 2'd2);

    // Random correct hits up to score 7, then held keys with a last-cycle hit
    repeat (6) run_round($urandom_range(1, m_window()), 0, 0);
    run_round(m_window(), 0, 1);
    chk("score_eight", score, 8'd8);

    // Timeout measures the (possibly shortened) window, then a wrong key ends the game
    run_round(0, 0, 0);
    run_round($urandom_range(1, m_window()), 1, 0);
    check_over_ignores_start();
    clear_game();

    // Three misses by wrong keys
    run_round($urandom_range(1, m_window()), 1, 0);
    run_round($urandom_range(1, m_window()), 2, 0);
    run_round($urandom_range(1, m_window()), 1, 0);
    check_over_ignores_start();
    clear_game();

    // Reset in the middle of ACTIVE
    round_start = 1'b1;
    step();
    round_start = 1'b0;
    step();
    step();
    Resetn = 1'b0;
    #1;
    m_score = 0;
    m_lives = 3;
    chk("midrst_mole", mole, 4'b0000);
    chk("midrst_done", round_done, 1'b0);
    chk("midrst_lives", lives, 2'd3);
    step();
    chk("midrst_no_done", round_done, 1'b0);
    Resetn = 1'b1;
    step();

    // Saturate the score
    for (int i = 0; i < 260; i++) run_round($urandom_range(1, m_window()), 0, 0);
    chk("score_saturated", score, 8'd255);
    run_round(0, 0, 0);
    chk("score_held_after_miss", score, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

endmodule
